cpu_phase_gen: RTL and testbench

- Parametrised multi-phase timing generator for the multi-cycle MIPS datapath; replaces fixed divide-by-2/4/8 strobe generation.
- Sequences an instruction cycle of NUM_PHASES phases, each phase lasting (div_q+1) clk ticks.
- Adds run/halt control, stall freeze and single-step handshake.
- All outputs are clk-synchronous enables/strobes, not derived clocks; consumers gate on them.

---
 rtl/cpu_phase_gen.sv | 190 +++++++++++++++++++
 tb/tb_cpu_phase_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_phase_gen.sv
// cpu_phase_gen: multi-phase timing generator for the multi-cycle MIPS datapath.
// Sequences an instruction cycle of NUM_PHASES phases, each (div_q+1) clk ticks
// long, with run/halt, stall freeze and a single-step handshake. Every output is
// a clk-synchronous enable/strobe; consumers gate on them instead of using
// derived clocks.
// Optional build macro PHASE_GEN_CYCLE_CNT_EN adds i_cnt_clr and o_cycle_cnt,
// a 32-bit count of completed cycles.
module cpu_phase_gen #(
    parameter int NUM_PHASES = 8,
    parameter int PH_W       = 3,
    parameter int DIV_W      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_run,
    input  logic                  i_stall,
    input  logic                  i_step_req,
    input  logic [DIV_W-1:0]      i_div_sel,
`ifdef PHASE_GEN_CYCLE_CNT_EN
    input  logic                  i_cnt_clr,
    output logic [31:0]           o_cycle_cnt,
`endif
    output logic [NUM_PHASES-1:0] o_phase_onehot,
    output logic [PH_W-1:0]       o_phase_idx,
    output logic                  o_phase_tick,
    output logic                  o_cycle_start,
    output logic                  o_cycle_end,
    output logic                  o_fetch_en,
    output logic                  o_busy,
    output logic                  o_step_ack
);

    localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);
    localparam logic [PH_W-1:0] HALF_PH = PH_W'(NUM_PHASES / 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_q;
    logic [PH_W-1:0]  r_phase;
    logic             r_tick;
    logic             r_cstart;
    logic             r_ack;

    state_t           w_state_nx;
    logic [DIV_W-1:0] w_cnt_nx;
    logic [DIV_W-1:0] w_div_q_nx;
    logic [PH_W-1:0]  w_phase_nx;
    logic             w_tick_nx;
    logic             w_cstart_nx;
    logic             w_ack_nx;

    logic             w_busy;
    logic             w_last_tick;
    logic             w_last_phase;
    logic             w_cycle_end;
    logic [NUM_PHASES-1:0] w_onehot;

    assign w_busy       = (r_state != ST_IDLE);
    assign w_last_tick  = (r_cnt == r_div_q);
    assign w_last_phase = (r_phase == LAST_PH);
    // The end-of-cycle strobe covers the whole last tick but must vanish at once under stall.
    assign w_cycle_end  = w_busy & w_last_phase & w_last_tick & ~i_stall;

    // Next-state logic: stall freezes everything; otherwise start, tick, advance or wrap.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_div_q_nx  = r_div_q;
        w_phase_nx  = r_phase;
        w_tick_nx   = r_tick;
        w_cstart_nx = r_cstart;
        w_ack_nx    = 1'b0;
        if (!i_stall) begin
            w_tick_nx   = 1'b0;
            w_cstart_nx = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // run wins over a simultaneous step request
                    if (i_run || i_step_req) begin
                        w_state_nx  = i_run ? ST_RUN : ST_STEP;
                        w_cnt_nx    = {DIV_W{1'b0}};
                        w_div_q_nx  = i_div_sel;
                        w_phase_nx  = {PH_W{1'b0}};
                        w_tick_nx   = 1'b1;
                        w_cstart_nx = 1'b1;
                    end else begin
                        w_state_nx  = ST_IDLE;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (w_last_tick) begin
                        w_cnt_nx = {DIV_W{1'b0}};
                        if (w_last_phase) begin
                            if ((r_state == ST_RUN) && i_run) begin
                                w_div_q_nx  = i_div_sel;
                                w_phase_nx  = {PH_W{1'b0}};
                                w_tick_nx   = 1'b1;
                                w_cstart_nx = 1'b1;
                            end else begin
                                // halt or single-step completion: back to reset-like idle
                                w_state_nx  = ST_IDLE;
                                w_div_q_nx  = {DIV_W{1'b0}};
                                w_phase_nx  = {PH_W{1'b0}};
                                w_ack_nx    = (r_state == ST_STEP);
                            end
                        end else begin
                            w_phase_nx = r_phase + PH_W'(1);
                            w_tick_nx  = 1'b1;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = {DIV_W{1'b0}};
                    w_div_q_nx = {DIV_W{1'b0}};
                    w_phase_nx = {PH_W{1'b0}};
                end
            endcase
        end else begin
            w_ack_nx = 1'b0;
        end
    end

    // State and sequencing registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= {DIV_W{1'b0}};
            r_div_q  <= {DIV_W{1'b0}};
            r_phase  <= {PH_W{1'b0}};
            r_tick   <= 1'b0;
            r_cstart <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_div_q  <= w_div_q_nx;
            r_phase  <= w_phase_nx;
            r_tick   <= w_tick_nx;
            r_cstart <= w_cstart_nx;
            r_ack    <= w_ack_nx;
        end
    end

    // One-hot phase decode, all-zero while idle.
    always_comb begin
        w_onehot = {NUM_PHASES{1'b0}};
        for (int i = 0; i < NUM_PHASES; i++) begin
            w_onehot[i] = w_busy && (r_phase == PH_W'(i));
        end
    end

    assign o_phase_onehot = w_onehot;
    assign o_phase_idx    = r_phase;
    // Entry strobes stay pending through a stall so each fires exactly once per phase.
    assign o_phase_tick   = r_tick & ~i_stall;
    assign o_cycle_start  = r_cstart & ~i_stall;
    assign o_cycle_end    = w_cycle_end;
    assign o_fetch_en     = w_busy & (r_phase < HALF_PH);
    assign o_busy         = w_busy;
    assign o_step_ack     = r_ack;

`ifdef PHASE_GEN_CYCLE_CNT_EN
    logic [31:0] r_cycle_cnt;

    // Completed-cycle counter; clear beats increment, wraps naturally at 2^32.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cycle_cnt <= 32'd0;
        end else if (i_cnt_clr) begin
            r_cycle_cnt <= 32'd0;
        end else if (w_cycle_end) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end else begin
            r_cycle_cnt <= r_cycle_cnt;
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_cpu_phase_gen.sv
// Directed, scoreboard-driven bench for cpu_phase_gen (NUM_PHASES=8).
// Each step drives inputs just after a rising edge; the expected outputs for
// that clk are pushed beforehand and popped/compared once inputs settle.
module tb_cpu_phase_gen;

    localparam int NP = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       stall = 1'b0;
    logic       step_req = 1'b0;
    logic [3:0] div_sel = 4'd0;

    logic [7:0] phase_onehot;
    logic [2:0] phase_idx;
    logic       phase_tick, cycle_start, cycle_end, fetch_en, busy, step_ack;
`ifdef PHASE_GEN_CYCLE_CNT_EN
    logic        cnt_clr = 1'b0;
    logic [31:0] cycle_cnt;
`endif

    always #5 clk = ~clk;

    cpu_phase_gen #(.NUM_PHASES(8), .PH_W(3), .DIV_W(4)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_run          (run),
        .i_stall        (stall),
        .i_step_req     (step_req),
        .i_div_sel      (div_sel),
`ifdef PHASE_GEN_CYCLE_CNT_EN
        .i_cnt_clr      (cnt_clr),
        .o_cycle_cnt    (cycle_cnt),
`endif
        .o_phase_onehot (phase_onehot),
        .o_phase_idx    (phase_idx),
        .o_phase_tick   (phase_tick),
        .o_cycle_start  (cycle_start),
        .o_cycle_end    (cycle_end),
        .o_fetch_en     (fetch_en),
        .o_busy         (busy),
        .o_step_ack     (step_ack)
    );

    typedef struct {
        logic [2:0]  idx;
        logic [7:0]  oh;
        logic        tick;
        logic        start;
        logic        endd;
        logic        fetch;
        logic        busy;
        logic        ack;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_idle(input logic ack);
        exp_t e;
        e.idx = 3'd0; e.oh = 8'd0; e.tick = 1'b0; e.start = 1'b0; e.endd = 1'b0;
        e.fetch = 1'b0; e.busy = 1'b0; e.ack = ack; e.cnt = 32'(exp_cnt);
        sb.push_back(e);
    endtask

    // p = phase, t = tick within phase, dv = active divider, st = stalled this clk
    task automatic push_act(input int p, input int t, input int dv, input bit st);
        exp_t e;
        e.idx   = 3'(p);
        e.oh    = 8'(1 << p);
        e.tick  = (t == 0) && !st;
        e.start = (p == 0) && (t == 0) && !st;
        e.endd  = (p == NP - 1) && (t == dv) && !st;
        e.fetch = (p < NP / 2);
        e.busy  = 1'b1;
        e.ack   = 1'b0;
        e.cnt   = 32'(exp_cnt);
        sb.push_back(e);
        if (e.endd) exp_cnt++;
    endtask

    task automatic check_outputs();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk("phase_idx",    32'(phase_idx),    32'(e.idx));
            chk("phase_onehot", 32'(phase_onehot), 32'(e.oh));
            chk("phase_tick",   32'(phase_tick),   32'(e.tick));
            chk("cycle_start",  32'(cycle_start),  32'(e.start));
            chk("cycle_end",    32'(cycle_end),    32'(e.endd));
            chk("fetch_en",     32'(fetch_en),     32'(e.fetch));
            chk("busy",         32'(busy),         32'(e.busy));
            chk("step_ack",     32'(step_ack),     32'(e.ack));
`ifdef PHASE_GEN_CYCLE_CNT_EN
            chk("cycle_cnt",    cycle_cnt,         e.cnt);
`endif
        end
    endtask

    // One clk: wait for the edge, drive this clk's inputs, then compare.
    task automatic cyc(input logic rs, input logic r, input logic s, input logic sr, input logic [3:0] d);
        @(posedge clk);
        #1;
        reset = rs; run = r; stall = s; step_req = sr; div_sel = d;
        #1;
        check_outputs();
    endtask

    initial begin
        // reset state
        push_idle(1'b0); cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        push_idle(1'b0); cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        // free run div 0: two full cycles, then drop run at phase 3
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < NP; p++) begin
                push_act(p, 0, 0, 1'b0); cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            end
        for (int p = 0; p < NP; p++) begin
            push_act(p, 0, 0, 1'b0); cyc(1'b0, (p < 3), 1'b0, 1'b0, 4'd0);
        end
        push_idle(1'b0); cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        push_idle(1'b0); cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd2);

        // div 2, div_sel changed to 0 mid-cycle, applied only from next cycle
        push_idle(1'b0); cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        for (int p = 0; p < NP; p++)
            for (int t = 0; t < 3; t++) begin
                push_act(p, t, 2, 1'b0); cyc(1'b0, 1'b1, 1'b0, 1'b0, (p >= 2) ? 4'd0 : 4'd2);
            end
        for (int p = 0; p < NP; p++) begin
            push_act(p, 0, 0, 1'b0); cyc(1'b0, (p != NP - 1), 1'b0, 1'b0, 4'd0);
        end
        push_idle(1'b0); cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd1);

        // div 1 with a 5-clk stall in phase 5 and a 2-clk stall over cycle_end
        push_idle(1'b0); cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        for (int p = 0; p < 5; p++)
            for (int t = 0; t < 2; t++) begin
                push_act(p, t, 1, 1'b0); cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
            end
        push_act(5, 0, 1, 1'b0); cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        for (int k = 0; k < 5; k++) begin
            push_act(5, 1, 1, 1'b1); cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
        end
        push_act(5, 1, 1, 1'b0); cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        push_act(6, 0, 1, 1'b0); cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        push_act(6, 1, 1, 1'b0); cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        push_act(7, 0, 1, 1'b0); cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        for (int k = 0; k < 2; k++) begin
            push_act(7, 1, 1, 1'b1); cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
        end
        push_act(7, 1, 1, 1'b0); cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        push_idle(1'b0); cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // single step; a second request during STEP must be dropped
        push_idle(1'b0); cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        for (int p = 0; p < NP; p++) begin
            push_act(p, 0, 0, 1'b0); cyc(1'b0, 1'b0, 1'b0, (p == 2), 4'd0);
        end
        push_idle(1'b1); cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        push_idle(1'b0); cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        push_idle(1'b0); cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // run and step together: run wins, so no step_ack at the end
        push_idle(1'b0); cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        for (int p = 0; p < NP; p++) begin
            push_act(p, 0, 0, 1'b0); cyc(1'b0, (p != NP - 1), 1'b0, 1'b0, 4'd0);
        end
        push_idle(1'b0); cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // reset at phase 6 aborts the cycle; then three full cycles
        push_idle(1'b0); cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int p = 0; p < 7; p++) begin
            push_act(p, 0, 0, 1'b0); cyc((p == 6), 1'b1, 1'b0, 1'b0, 4'd0);
        end
        exp_cnt = 0;
        push_idle(1'b0); cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int c = 0; c < 3; c++)
            for (int p = 0; p < NP; p++) begin
                push_act(p, 0, 0, 1'b0); cyc(1'b0, !((c == 2) && (p == NP - 1)), 1'b0, 1'b0, 4'd0);
            end
        push_idle(1'b0); cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
